// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array kernel controller.
package sys_array_pkg;

    // Upper bound on the number of channels one controller can manage.
    localparam int NUM_CH_MAX = 16;

    // Width of the run-length counter reported to the host.
    localparam int BUSY_WIDTH = 32;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } kstate_t;

endpackage

// File: rtl/sys_array_done_tracker.sv
// Sticky per-channel done mask and the "every enabled channel finished" compare.
// all_done includes this cycle's pulses so the controller can leave RUN in the
// same cycle the last channel reports.
module sys_array_done_tracker
    import sys_array_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear,
    input  logic              capture,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic [NUM_CH-1:0] ch_done,
    output logic [NUM_CH-1:0] done_status,
    output logic              all_done
);

    logic [NUM_CH-1:0] hits;

    assign hits     = ch_done & en_mask;
    assign all_done = ((done_status | hits) == en_mask);

    // Accumulate done pulses from enabled channels while capture is open.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_status <= '0;
        end else if (clear) begin
            done_status <= '0;
        end else if (capture) begin
            done_status <= done_status | hits;
        end
    end

endmodule

// File: rtl/sys_array_kernel_ctrl.sv
// Kernel controller: accepts a host start, pulses the enabled channels, waits
// for every enabled channel to report done (or the watchdog to expire), then
// signals completion with ap_ctrl_hs or ap_ctrl_chain semantics.
//
// Handshake: a start is a rising edge of ap_start seen while idle; edges at
// any other time are dropped. ap_done/ap_ready mark the DONE state. In hs mode
// DONE lasts one cycle; in chain mode ap_ready pulses on the first DONE cycle,
// ap_done holds until ap_continue is sampled high, and the controller returns
// to IDLE on that edge.
module sys_array_kernel_ctrl
    import sys_array_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int CHAIN_MODE    = 0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    input  logic                     ap_continue,
    output logic                     ap_idle,
    output logic                     ap_done,
    output logic                     ap_ready,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic [NUM_CH-1:0]        ch_start,
    input  logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_done_status,
    output logic                     timeout_err,
    output logic [BUSY_WIDTH-1:0]    busy_cycles,
    output kstate_t                  fsm_state
);

    if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("sys_array_kernel_ctrl: NUM_CH must be in 1..NUM_CH_MAX");
    end

    kstate_t                  state_q;
    kstate_t                  state_d;
    logic                     start_q;
    logic                     start_accept;
    logic [NUM_CH-1:0]        en_mask_q;
    logic [TIMEOUT_WIDTH-1:0] run_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] run_cnt_cur;
    logic                     timeout_hit;
    logic [BUSY_WIDTH-1:0]    busy_q;
    logic                     timeout_err_q;
    logic                     in_done_q;
    logic                     all_done;
    logic                     capture;

    // The RUN cycle currently in progress, counted from 1.
    assign run_cnt_cur  = run_cnt_q + TIMEOUT_WIDTH'(1);
    assign timeout_hit  = (timeout_cycles != '0) && (run_cnt_cur == timeout_cycles);
    assign start_accept = (state_q == ST_IDLE) && ap_start && !start_q;
    assign capture      = (state_q == ST_LAUNCH) || (state_q == ST_RUN);

    sys_array_done_tracker #(
        .NUM_CH (NUM_CH)
    ) u_done_tracker (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .clear       (start_accept),
        .capture     (capture),
        .en_mask     (en_mask_q),
        .ch_done     (ch_done),
        .done_status (ch_done_status),
        .all_done    (all_done)
    );

    // Previous ap_start level for edge detection; 0 in reset so a start held
    // through reset release still counts as an edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= ap_start;
        end
    end

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; completion wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = (ch_enable != '0) ? ST_LAUNCH : ST_DONE;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (all_done || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (CHAIN_MODE == 0 || ap_continue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run bookkeeping: enable mask, RUN-cycle counter, busy counter, watchdog flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            en_mask_q     <= '0;
            run_cnt_q     <= '0;
            busy_q        <= '0;
            timeout_err_q <= 1'b0;
            in_done_q     <= 1'b0;
        end else begin
            in_done_q <= (state_q == ST_DONE);
            if (start_accept) begin
                en_mask_q     <= ch_enable;
                busy_q        <= '0;
                timeout_err_q <= 1'b0;
            end else if (capture && busy_q != '1) begin
                busy_q <= busy_q + BUSY_WIDTH'(1);
            end
            if (state_q == ST_LAUNCH) begin
                run_cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                run_cnt_q <= run_cnt_cur;
                if (timeout_hit && !all_done) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        ch_start = '0;
        case (state_q)
            ST_IDLE:   ap_idle = 1'b1;
            ST_LAUNCH: ch_start = en_mask_q;
            ST_DONE: begin
                ap_done  = 1'b1;
                ap_ready = !in_done_q;
            end
            default: ;
        endcase
    end

    assign timeout_err = timeout_err_q;
    assign busy_cycles = busy_q;
    assign fsm_state   = state_q;

endmodule
